// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Hits complete with no stall; misses stall while whole lines move over a req/ack bus.
module dcache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int IDX_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  localparam int LINES  = 1 << IDX_W;
  localparam int BYTE_W = $clog2(DATA_W/8);
  localparam int OFF_W  = $clog2(LINE_W/8);
  localparam int WORD_W = OFF_W - BYTE_W;
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [2:0] {IDLE, MISS, WB, FETCH, DONE} state_t;
  state_t state;

  logic [LINE_W-1:0] dataArr [LINES];
  logic [TAG_W-1:0]  tagArr  [LINES];
  logic [LINES-1:0]  valid, dirty;

  logic [WORD_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [LINE_W-1:0] curLine;
  logic [DATA_W-1:0] curWord;
  logic [ADDR_W-1:0] newAddr, oldAddr;
  logic              req, hit, hitWrite, fill;
  logic              unusedAddrBits;

  assign offset  = cpu_addr_i[OFF_W-1:BYTE_W];
  assign idx     = cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign tag     = cpu_addr_i[ADDR_W-1:OFF_W+IDX_W];
  assign unusedAddrBits = ^cpu_addr_i[BYTE_W-1:0];

  assign curLine = dataArr[idx];
  assign curWord = curLine[offset*DATA_W +: DATA_W];
  assign newAddr = {tag, idx, {OFF_W{1'b0}}};
  assign oldAddr = {tagArr[idx], idx, {OFF_W{1'b0}}};

  assign req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit      = valid[idx] & (tagArr[idx] == tag);
  // Simultaneous read+write is a store.
  assign hitWrite = (state == IDLE) & cpu_MemWrite_i & hit;
  assign fill     = (state == FETCH) & mem_ack_i;

  // Gated by reset so an abandoned miss releases the pipeline immediately.
  assign cpu_stall_o = rst_i & ((state != IDLE) | (req & ~hit));
  assign cpu_data_o  = ((state == IDLE) & cpu_MemRead_i & hit) ? curWord : '0;

  // Line storage is not reset; valid bits alone make the contents meaningful.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      dataArr[idx] <= mem_data_i;
      tagArr[idx]  <= tag;
    end else if (hitWrite) begin
      dataArr[idx][offset*DATA_W +: DATA_W] <= cpu_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req & ~hit)   state <= MISS;
          else if (hitWrite) dirty[idx] <= 1'b1;
        end
        MISS: begin
          mem_enable_o <= 1'b1;
          if (valid[idx] & dirty[idx]) begin
            state       <= WB;
            mem_write_o <= 1'b1;
            mem_addr_o  <= oldAddr;
            mem_data_o  <= curLine;
          end else begin
            state       <= FETCH;
            mem_write_o <= 1'b0;
            mem_addr_o  <= newAddr;
          end
        end
        WB: begin
          if (mem_ack_i) begin
            state       <= FETCH;
            mem_write_o <= 1'b0;
            mem_addr_o  <= newAddr;
          end
        end
        FETCH: begin
          if (mem_ack_i) begin
            state        <= DONE;
            valid[idx]   <= 1'b1;
            dirty[idx]   <= 1'b0;
            mem_enable_o <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold miss, store hit, dirty eviction,
// ack latency, spurious ack, reset mid-fetch and read+write collision.
module tb_dcache_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_MemRead_i, cpu_MemWrite_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;

  int nChecks = 0;
  int nErr    = 0;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .cpu_stall_o(cpu_stall_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic lw(input logic [31:0] a);
    cpu_MemRead_i = 1'b1; cpu_MemWrite_i = 1'b0; cpu_addr_i = a; #1;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b1; cpu_addr_i = a; cpu_data_i = d; #1;
  endtask

  // Enable is already high; hold ack off for lat-1 cycles, pulse it, expect enable to drop.
  task automatic serveFetch(input string tag, input int lat, input logic [255:0] line);
    for (int i = 1; i < lat; i++) begin
      chk({tag, "_en_wait"}, mem_enable_o, 1'b1);
      tick();
    end
    chk({tag, "_en_ack"}, mem_enable_o, 1'b1);
    mem_ack_i = 1'b1; mem_data_i = line;
    tick();
    mem_ack_i = 1'b0;
    chk({tag, "_en_drop"}, mem_enable_o, 1'b0);
    chk({tag, "_done_stall"}, cpu_stall_o, 1'b1);
    tick();
  endtask

  // Request cycle already applied: expect stall, MISS, then a clean FETCH of addr.
  task automatic missToFetch(input string tag, input logic [31:0] addr);
    chk({tag, "_req_stall"}, cpu_stall_o, 1'b1);
    tick();
    chk({tag, "_miss_en"}, mem_enable_o, 1'b0);
    tick();
    chk({tag, "_fetch_addr"}, mem_addr_o, addr);
    chk({tag, "_fetch_wr"}, mem_write_o, 1'b0);
  endtask

  logic [255:0] line;

  initial begin
    rst_i = 1'b0; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    cpu_addr_i = '0; cpu_data_i = '0; mem_data_i = '0; mem_ack_i = 1'b0;
    tick(); tick();
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_en", mem_enable_o, 1'b0);
    chk("rst_wr", mem_write_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_mdata", mem_data_o[63:0], 64'h0);
    chk("rst_cdata", cpu_data_o, 32'h0);
    rst_i = 1'b1; tick();

    // 1: cold read at 0x020
    lw(32'h020);
    missToFetch("t1", 32'h020);
    line = '0; line[31:0] = 32'hDEADBEEF; line[63:32] = 32'h0BADF00D;
    serveFetch("t1", 2, line);
    chk("t1_stall", cpu_stall_o, 1'b0);
    chk("t1_data", cpu_data_o, 32'hDEADBEEF);

    // 2: store hit then load back
    sw(32'h024, 32'h12345678);
    chk("t2_sw_stall", cpu_stall_o, 1'b0);
    tick();
    lw(32'h024);
    chk("t2_lw_stall", cpu_stall_o, 1'b0);
    chk("t2_lw_data", cpu_data_o, 32'h12345678);
    lw(32'h020);
    chk("t2_word0", cpu_data_o, 32'hDEADBEEF);
    cpu_MemRead_i = 1'b0; #1;
    chk("t2_noreq_data", cpu_data_o, 32'h0);

    // 3: conflicting read evicts dirty line 1
    lw(32'h420);
    chk("t3_req_stall", cpu_stall_o, 1'b1);
    tick();
    chk("t3_miss_stall", cpu_stall_o, 1'b1);
    tick();
    chk("t3_wb_en", mem_enable_o, 1'b1);
    chk("t3_wb_wr", mem_write_o, 1'b1);
    chk("t3_wb_addr", mem_addr_o, 32'h020);
    chk("t3_wb_w1", mem_data_o[63:32], 32'h12345678);
    chk("t3_wb_w0", mem_data_o[31:0], 32'hDEADBEEF);
    tick();
    chk("t3_wb_hold", mem_enable_o, 1'b1);
    mem_ack_i = 1'b1; tick(); mem_ack_i = 1'b0;
    chk("t3_fetch_addr", mem_addr_o, 32'h420);
    chk("t3_fetch_wr", mem_write_o, 1'b0);
    chk("t3_fetch_stall", cpu_stall_o, 1'b1);
    line = '0; line[31:0] = 32'hCAFEF00D;
    serveFetch("t3", 3, line);
    chk("t3_stall", cpu_stall_o, 1'b0);
    chk("t3_data", cpu_data_o, 32'hCAFEF00D);

    // 4: ack latency 1 and 12, then spurious ack
    lw(32'h040);
    missToFetch("t4a", 32'h040);
    line = '0; line[31:0] = 32'h11111111;
    serveFetch("t4a", 1, line);
    chk("t4a_data", cpu_data_o, 32'h11111111);
    lw(32'h06C);
    missToFetch("t4b", 32'h060);
    line = '0; line[127:96] = 32'h22223333;
    serveFetch("t4b", 12, line);
    chk("t4b_data", cpu_data_o, 32'h22223333);
    mem_ack_i = 1'b1; mem_data_i = '1; tick(); mem_ack_i = 1'b0;
    chk("t4_spur_en", mem_enable_o, 1'b0);
    chk("t4_spur_stall", cpu_stall_o, 1'b0);
    chk("t4_spur_data", cpu_data_o, 32'h22223333);

    // 5: reset during FETCH (line 1 is clean, tag 1)
    lw(32'h020);
    missToFetch("t5", 32'h020);
    chk("t5_fetch_en", mem_enable_o, 1'b1);
    #1 rst_i = 1'b0; #1;
    chk("t5_rst_en", mem_enable_o, 1'b0);
    chk("t5_rst_stall", cpu_stall_o, 1'b0);
    mem_ack_i = 1'b1; tick(); mem_ack_i = 1'b0;
    rst_i = 1'b1; #1;
    lw(32'h020);
    missToFetch("t5r", 32'h020);
    line = '0; line[31:0] = 32'h55550000; line[95:64] = 32'h0;
    serveFetch("t5r", 2, line);
    chk("t5r_data", cpu_data_o, 32'h55550000);

    // 6: read+write together on a hit behaves as a store
    cpu_MemRead_i = 1'b1; cpu_MemWrite_i = 1'b1; cpu_addr_i = 32'h028; cpu_data_i = 32'hAAAA5555; #1;
    chk("t6_stall", cpu_stall_o, 1'b0);
    tick();
    lw(32'h028);
    chk("t6_data", cpu_data_o, 32'hAAAA5555);
    lw(32'h420);
    chk("t6_req_stall", cpu_stall_o, 1'b1);
    tick(); tick();
    chk("t6_wb_wr", mem_write_o, 1'b1);
    chk("t6_wb_addr", mem_addr_o, 32'h020);
    chk("t6_wb_w2", mem_data_o[95:64], 32'hAAAA5555);
    mem_ack_i = 1'b1; tick(); mem_ack_i = 1'b0;
    line = '0; line[31:0] = 32'h77778888;
    serveFetch("t6", 1, line);
    chk("t6_final", cpu_data_o, 32'h77778888);

    cpu_MemRead_i = 1'b0; tick();
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
